// File: rtl/fifo_1r1w_prog.sv
// Single-clock valid/ready FIFO with configurable width/depth, occupancy count,
// programmable almost-full/almost-empty flags, synchronous flush and a high-water mark.
module fifo_1r1w_prog #(
  parameter int width_p     = 8,
  parameter int depth_p     = 8,
  parameter int af_thresh_p = 6,
  parameter int ae_thresh_p = 2
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic                         flush_i,
  input  logic [width_p-1:0]           data_i,
  input  logic                         valid_i,
  output logic                         ready_o,
  output logic [width_p-1:0]           data_o,
  output logic                         valid_o,
  input  logic                         ready_i,
  output logic [$clog2(depth_p+1)-1:0] count_o,
  output logic                         almost_full_o,
  output logic                         almost_empty_o,
  output logic [$clog2(depth_p+1)-1:0] max_count_o
);

  localparam int cnt_w = $clog2(depth_p + 1);
  localparam int ptr_w = $clog2(depth_p);
  localparam logic [cnt_w-1:0] full_c  = cnt_w'(depth_p);
  localparam logic [cnt_w-1:0] af_c    = cnt_w'(af_thresh_p);
  localparam logic [cnt_w-1:0] ae_c    = cnt_w'(ae_thresh_p);
  localparam logic [ptr_w-1:0] last_c  = ptr_w'(depth_p - 1);

  if (depth_p < 2) begin : g_bad_depth
    $error("fifo_1r1w_prog: depth_p must be >= 2");
  end
  if (af_thresh_p < 1 || af_thresh_p > depth_p) begin : g_bad_af
    $error("fifo_1r1w_prog: af_thresh_p must be in 1..depth_p");
  end
  if (ae_thresh_p < 0 || ae_thresh_p >= depth_p) begin : g_bad_ae
    $error("fifo_1r1w_prog: ae_thresh_p must be in 0..depth_p-1");
  end

  logic [width_p-1:0] mem [depth_p];
  logic [ptr_w-1:0]   wr_ptr_r, rd_ptr_r;
  logic [cnt_w-1:0]   count_r, count_nxt, max_r;
  logic               wr_en, rd_en;

  // Handshake qualifiers depend only on state and flush, never on valid_i/ready_i.
  assign ready_o = (count_r != full_c) & ~flush_i;
  assign valid_o = (count_r != '0) & ~flush_i;
  assign wr_en   = valid_i & ready_o;
  assign rd_en   = valid_o & ready_i;

  assign data_o         = mem[rd_ptr_r];
  assign count_o        = count_r;
  assign max_count_o    = max_r;
  assign almost_full_o  = (count_r >= af_c);
  assign almost_empty_o = (count_r <= ae_c);

  always_comb begin
    count_nxt = count_r;
    if (flush_i)
      count_nxt = '0;
    else if (wr_en && !rd_en)
      count_nxt = count_r + cnt_w'(1);
    else if (rd_en && !wr_en)
      count_nxt = count_r - cnt_w'(1);
  end

  // Storage carries no reset; contents are qualified by count_r.
  always_ff @(posedge clk_i) begin
    if (wr_en)
      mem[wr_ptr_r] <= data_i;
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
      max_r    <= '0;
    end else begin
      count_r <= count_nxt;
      if (count_nxt > max_r)
        max_r <= count_nxt;
      if (flush_i) begin
        wr_ptr_r <= '0;
        rd_ptr_r <= '0;
      end else begin
        if (wr_en)
          wr_ptr_r <= (wr_ptr_r == last_c) ? '0 : wr_ptr_r + ptr_w'(1);
        if (rd_en)
          rd_ptr_r <= (rd_ptr_r == last_c) ? '0 : rd_ptr_r + ptr_w'(1);
      end
    end
  end

endmodule

// File: tb/tb_fifo_1r1w_prog.sv
// Bench for fifo_1r1w_prog: queue-based reference model checked every cycle on a
// depth-8 and a depth-5 build, plus directed scenarios with literal expectations.
module tb_fifo_1r1w_prog;

  logic       clk = 1'b0;
  logic       rst_n, flush, valid_in, ready_in;
  logic [7:0] din;

  logic       ro8, vo8, af8, ae8, ro5, vo5, af5, ae5;
  logic [7:0] do8, do5;
  logic [3:0] c8, m8;
  logic [2:0] c5, m5;

  fifo_1r1w_prog #(.width_p(8), .depth_p(8), .af_thresh_p(6), .ae_thresh_p(2)) u8 (
    .clk_i(clk), .reset_i(rst_n), .flush_i(flush), .data_i(din), .valid_i(valid_in),
    .ready_o(ro8), .data_o(do8), .valid_o(vo8), .ready_i(ready_in), .count_o(c8),
    .almost_full_o(af8), .almost_empty_o(ae8), .max_count_o(m8));

  fifo_1r1w_prog #(.width_p(8), .depth_p(5), .af_thresh_p(4), .ae_thresh_p(1)) u5 (
    .clk_i(clk), .reset_i(rst_n), .flush_i(flush), .data_i(din), .valid_i(valid_in),
    .ready_o(ro5), .data_o(do5), .valid_o(vo5), .ready_i(ready_in), .count_o(c5),
    .almost_full_o(af5), .almost_empty_o(ae5), .max_count_o(m5));

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  logic [7:0] q8[$];
  logic [7:0] q5[$];
  int mx8 = 0;
  int mx5 = 0;
  bit w8, r8, w5, r5;

  task automatic check(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Expected outputs derived from queue occupancy and the flag thresholds.
  task automatic cmp_one(input string tag, input int d, input int af, input int ae,
                         input int sz, input int mx, input int head,
                         input logic vo, input logic ro, input logic [7:0] dout,
                         input int cnt, input int mxo, input logic afo, input logic aeo);
    check({tag, ".valid_o"}, int'(vo), int'(sz != 0 && !flush));
    check({tag, ".ready_o"}, int'(ro), int'(sz != d && !flush));
    check({tag, ".count_o"}, cnt, sz);
    check({tag, ".max_count_o"}, mxo, mx);
    check({tag, ".almost_full_o"}, int'(afo), int'(sz >= af));
    check({tag, ".almost_empty_o"}, int'(aeo), int'(sz <= ae));
    if (sz != 0) check({tag, ".data_o"}, int'(dout), head);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      cmp_one("d8", 8, 6, 2, q8.size(), mx8, (q8.size() != 0) ? int'(q8[0]) : 0,
              vo8, ro8, do8, int'(c8), int'(m8), af8, ae8);
      cmp_one("d5", 5, 4, 1, q5.size(), mx5, (q5.size() != 0) ? int'(q5[0]) : 0,
              vo5, ro5, do5, int'(c5), int'(m5), af5, ae5);
    end
  end

  always @(posedge clk) begin
    if (rst_n) begin
      w8 = valid_in && q8.size() < 8 && !flush;
      r8 = ready_in && q8.size() > 0 && !flush;
      w5 = valid_in && q5.size() < 5 && !flush;
      r5 = ready_in && q5.size() > 0 && !flush;
      if (flush) begin
        q8.delete();
        q5.delete();
      end else begin
        if (r8) void'(q8.pop_front());
        if (w8) q8.push_back(din);
        if (r5) void'(q5.pop_front());
        if (w5) q5.push_back(din);
      end
      if (q8.size() > mx8) mx8 = q8.size();
      if (q5.size() > mx5) mx5 = q5.size();
    end
  end

  always @(negedge rst_n) begin
    q8.delete();
    q5.delete();
    mx8 = 0;
    mx5 = 0;
  end

  // Apply inputs for the next rising edge, then return just after it.
  task automatic step(input logic v, input logic [7:0] d, input logic r, input logic f);
    valid_in = v;
    din      = d;
    ready_in = r;
    flush    = f;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b1; flush = 1'b0; valid_in = 1'b0; ready_in = 1'b0; din = 8'h00;
    #2 rst_n = 1'b0;
    #1 chk_en = 1'b1;

    // Reset held for 10 cycles
    repeat (10) @(posedge clk);
    #1;
    check("rst.valid_o", int'(vo8), 0);
    check("rst.ready_o", int'(ro8), 1);
    check("rst.count_o", int'(c8), 0);
    check("rst.almost_empty_o", int'(ae8), 1);
    check("rst.almost_full_o", int'(af8), 0);
    rst_n = 1'b1;

    // Fill with 0x01..0x0A, no reads
    for (int i = 1; i <= 10; i++) begin
      step(1'b1, 8'(i), 1'b0, 1'b0);
      check("fill.count_o", int'(c8), (i > 8) ? 8 : i);
      check("fill.almost_full_o", int'(af8), int'(i >= 6));
    end
    check("fill.ready_o", int'(ro8), 0);
    check("fill.max_count_o", int'(m8), 8);
    for (int k = 1; k <= 8; k++) begin
      check("drain.data_o", int'(do8), k);
      step(1'b0, 8'h00, 1'b1, 1'b0);
    end
    check("drain.valid_o", int'(vo8), 0);

    // Full, then simultaneous valid/ready; pointers wrap
    for (int i = 0; i < 8; i++) step(1'b1, 8'h11 + 8'(i), 1'b0, 1'b0);
    step(1'b1, 8'h19, 1'b1, 1'b0);
    check("full.rd_only.count_o", int'(c8), 7);
    check("full.rd_only.data_o", int'(do8), 8'h12);
    step(1'b1, 8'h19, 1'b1, 1'b0);
    check("full.rd_wr.count_o", int'(c8), 7);
    check("full.rd_wr.data_o", int'(do8), 8'h13);
    for (int k = 0; k < 7; k++) begin
      check("wrap.data_o", int'(do8), 8'h13 + k);
      step(1'b0, 8'h00, 1'b1, 1'b0);
    end
    check("wrap.count_o", int'(c8), 0);

    // Flush with valid/ready both high
    for (int i = 0; i < 5; i++) step(1'b1, 8'hA0 + 8'(i), 1'b0, 1'b0);
    check("flush.pre.count_o", int'(c8), 5);
    valid_in = 1'b1; ready_in = 1'b1; flush = 1'b1; din = 8'hA5;
    #1;
    check("flush.ready_o_forced", int'(ro8), 0);
    check("flush.valid_o_forced", int'(vo8), 0);
    @(posedge clk); #1;
    flush = 1'b0; valid_in = 1'b0; ready_in = 1'b0;
    #1;
    check("flush.count_o", int'(c8), 0);
    check("flush.valid_o", int'(vo8), 0);
    check("flush.max_count_o", int'(m8), 8);

    // Asynchronous reset between edges at count 4
    for (int i = 0; i < 4; i++) step(1'b1, 8'hB0 + 8'(i), 1'b0, 1'b0);
    valid_in = 1'b0;
    check("areset.pre.count_o", int'(c8), 4);
    #1 rst_n = 1'b0;
    #1;
    check("areset.count_o", int'(c8), 0);
    check("areset.valid_o", int'(vo8), 0);
    check("areset.ready_o", int'(ro8), 1);
    check("areset.max_count_o", int'(m8), 0);
    check("areset.almost_empty_o", int'(ae8), 1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    step(1'b0, 8'h00, 1'b1, 1'b0);
    check("areset.post.valid_o", int'(vo8), 0);
    check("areset.post.count_o", int'(c8), 0);

    // Random traffic with occasional flush
    for (int i = 0; i < 1000; i++)
      step(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 9) < 8),
           1'($urandom_range(0, 99) < 2));
    step(1'b0, 8'h00, 1'b0, 1'b0);

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
